uart_tx_scheduler: RTL

//  Round-robin scheduler sharing one UART_Tx between NUM_REQ byte producers.

---
 rtl/uart_tx_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART transmitter among
// NUM_REQ byte producers, with an inter-frame gap and start/frame timeouts.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned START_TIMEOUT = 64,
    parameter int unsigned FRAME_TIMEOUT = 200000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [8*NUM_REQ-1:0]       req_data_i,
    input  logic [2*NUM_REQ-1:0]       req_parity_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [1:0]                 cfg_baud_rate_i,
    output logic                       tx_send_o,
    output logic [7:0]                 tx_data_in_o,
    output logic [1:0]                 tx_parity_type_o,
    output logic [1:0]                 tx_baud_rate_o,
    input  logic                       tx_active_flag_i,
    input  logic                       tx_done_flag_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       timeout_err_o
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned IDX_W = ID_W + 1;
    localparam int unsigned CNT_W = 20;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               tx_send_q, tx_send_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [1:0]         tx_par_q, tx_par_d;
    logic [1:0]         tx_baud_q, tx_baud_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic               timeout_c;
    logic               grant_vld_c;
    logic [ID_W-1:0]    grant_idx_c;
    logic [IDX_W-1:0]   scan_c;
    logic [IDX_W-1:0]   rr_next_c;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        scan_c      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_c = IDX_W'(rr_ptr_q) + IDX_W'(k);
            if (scan_c >= IDX_W'(NUM_REQ)) begin
                scan_c = scan_c - IDX_W'(NUM_REQ);
            end
            if (!grant_vld_c && req_valid_i[ID_W'(scan_c)]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = ID_W'(scan_c);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, phase counter and timeout detection
    always_comb begin
        state_d   = state_q;
        timeout_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_vld_c) state_d = SEND;
            end
            SEND: begin
                if (tx_active_flag_i) begin
                    if (tx_done_flag_i) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    else                state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    timeout_c = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_done_flag_i) begin
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (cnt_q == CNT_W'(FRAME_TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    timeout_c = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Counter measures cycles spent in the current non-idle state
        cnt_d = cnt_q + CNT_W'(1);
        if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;
    end

    // Output and payload next values; payload only changes on accept
    always_comb begin
        req_ready_d = '0;
        tx_data_d   = tx_data_q;
        tx_par_d    = tx_par_q;
        tx_baud_d   = tx_baud_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        rr_next_c   = IDX_W'(grant_idx_c) + IDX_W'(1);
        if ((state_q == IDLE) && grant_vld_c) begin
            req_ready_d[grant_idx_c] = 1'b1;
            tx_data_d  = req_data_i[8*grant_idx_c +: 8];
            tx_par_d   = req_parity_i[2*grant_idx_c +: 2];
            tx_baud_d  = cfg_baud_rate_i;
            grant_id_d = grant_idx_c;
            rr_ptr_d   = (rr_next_c == IDX_W'(NUM_REQ)) ? '0 : ID_W'(rr_next_c);
        end
        // send rises one cycle after accept and drops once active is seen
        tx_send_d = (state_q == SEND) && (state_d == SEND);
        busy_d    = (state_d != IDLE);
        timeout_d = timeout_c;
    end

    // Counter, pointer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            req_ready_q <= '0;
            tx_send_q   <= 1'b0;
            tx_data_q   <= '0;
            tx_par_q    <= '0;
            tx_baud_q   <= '0;
            grant_id_q  <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            req_ready_q <= req_ready_d;
            tx_send_q   <= tx_send_d;
            tx_data_q   <= tx_data_d;
            tx_par_q    <= tx_par_d;
            tx_baud_q   <= tx_baud_d;
            grant_id_q  <= grant_id_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign req_ready_o      = req_ready_q;
    assign tx_send_o        = tx_send_q;
    assign tx_data_in_o     = tx_data_q;
    assign tx_parity_type_o = tx_par_q;
    assign tx_baud_rate_o   = tx_baud_q;
    assign grant_id_o       = grant_id_q;
    assign busy_o           = busy_q;
    assign timeout_err_o    = timeout_q;

endmodule
